// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register and EX-side ALU operand selector.
// Optional load-use interlock (one bubble plus write-back forwarding) is
// compiled in when IDEX_LOAD_USE_EN is defined; without it stall_id only
// mirrors ex_hold and wb_data has no effect.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RUN    | normal flow; watches for a load in EX feeding the ID instruction
// ST_BUBBLE | bubble sits in EX, consumer is entering EX on this edge
// ST_LU_FWD | consumer in EX, matched operands take wb_data
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_is_load,
  input  logic            id_reg_write,
  input  logic            flush,
  input  logic            ex_hold,
  input  logic            fwd_rs1,
  input  logic            fwd_rs2,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [3:0]      ex_alu_op,
  output logic            ex_is_load,
  output logic            ex_reg_write,
  output logic            stall_id
);

  logic            ex_valid_q, ex_valid_d;
  logic [4:0]      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
  logic            use_imm_q, use_imm_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            is_load_q, is_load_d, reg_write_q, reg_write_d;
  logic [XLEN-1:0] last_result_q, last_result_d;

  logic bubble;
  logic lu_fwd_a, lu_fwd_b;

`ifdef IDEX_LOAD_USE_EN
  typedef enum logic [1:0] {ST_RUN, ST_BUBBLE, ST_LU_FWD} state_t;
  state_t state_q, state_d;
  logic   lu_a_q, lu_a_d, lu_b_q, lu_b_d;

  // Load in EX whose rd is read by the instruction waiting in ID.
  assign bubble = (state_q == ST_RUN) && id_valid && ex_valid_q && is_load_q &&
                  (ex_rd_q != 5'd0) && ((id_rs1 == ex_rd_q) || (id_rs2 == ex_rd_q)) &&
                  !flush && !ex_hold;

  // Next-state logic; flush always returns to RUN, hold freezes everything.
  always_comb begin
    state_d = state_q;
    lu_a_d  = lu_a_q;
    lu_b_d  = lu_b_q;
    if (flush) begin
      state_d = ST_RUN;
    end else if (!ex_hold) begin
      unique case (state_q)
        ST_RUN: begin
          if (bubble) begin
            state_d = ST_BUBBLE;
            lu_a_d  = (id_rs1 == ex_rd_q);
            lu_b_d  = (id_rs2 == ex_rd_q);
          end
        end
        ST_BUBBLE: state_d = ST_LU_FWD;
        ST_LU_FWD: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Interlock state and captured operand matches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      lu_a_q  <= 1'b0;
      lu_b_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lu_a_q  <= lu_a_d;
      lu_b_q  <= lu_b_d;
    end
  end

  assign lu_fwd_a = (state_q == ST_LU_FWD) && lu_a_q;
  assign lu_fwd_b = (state_q == ST_LU_FWD) && lu_b_q;
`else
  assign bubble   = 1'b0;
  assign lu_fwd_a = 1'b0;
  assign lu_fwd_b = 1'b0;
`endif

  // EX register update: flush, then hold, then bubble, then normal load.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_rd_d     = ex_rd_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    alu_op_d    = alu_op_q;
    is_load_d   = is_load_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_hold) begin
      ex_valid_d = ex_valid_q;
    end else if (bubble) begin
      ex_valid_d  = 1'b0;
      ex_rd_d     = 5'd0;
      reg_write_d = 1'b0;
    end else begin
      ex_valid_d  = id_valid;
      ex_rs1_d    = id_rs1;
      ex_rs2_d    = id_rs2;
      ex_rd_d     = id_rd;
      rs1_val_d   = id_rs1_val;
      rs2_val_d   = id_rs2_val;
      imm_d       = id_imm;
      use_imm_d   = id_use_imm;
      alu_op_d    = id_alu_op;
      is_load_d   = id_is_load;
      reg_write_d = id_reg_write;
    end
  end

  // Previous ALU result, kept for register forwarding.
  always_comb begin
    last_result_d = last_result_q;
    if (!ex_hold && ex_valid_q) last_result_d = alu_result;
  end

  // EX pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_rd_q       <= 5'd0;
      rs1_val_q     <= '0;
      rs2_val_q     <= '0;
      imm_q         <= '0;
      use_imm_q     <= 1'b0;
      alu_op_q      <= 4'd0;
      is_load_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      last_result_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      rs1_val_q     <= rs1_val_d;
      rs2_val_q     <= rs2_val_d;
      imm_q         <= imm_d;
      use_imm_q     <= use_imm_d;
      alu_op_q      <= alu_op_d;
      is_load_q     <= is_load_d;
      reg_write_q   <= reg_write_d;
      last_result_q <= last_result_d;
    end
  end

  // Operand A: x0 guard, then ALU forward, then load-use forward, then RF value.
  always_comb begin
    if (ex_rs1_q == 5'd0)  ex_op_a = '0;
    else if (fwd_rs1)      ex_op_a = last_result_q;
    else if (lu_fwd_a)     ex_op_a = wb_data;
    else                   ex_op_a = rs1_val_q;
  end

  // Operand B: immediate overrides the register chain.
  always_comb begin
    if (use_imm_q)              ex_op_b = imm_q;
    else if (ex_rs2_q == 5'd0)  ex_op_b = '0;
    else if (fwd_rs2)           ex_op_b = last_result_q;
    else if (lu_fwd_b)          ex_op_b = wb_data;
    else                        ex_op_b = rs2_val_q;
  end

  assign stall_id     = reset && (ex_hold || bubble);
  assign ex_valid     = ex_valid_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_is_load   = is_load_q;
  assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic,
// every cycle checked by a scoreboard against a behavioural model.
module tb_id_ex_stage;
  localparam int XLEN = 32;
`ifdef IDEX_LOAD_USE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            id_valid;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_val, id_rs2_val, id_imm;
  logic            id_use_imm;
  logic [3:0]      id_alu_op;
  logic            id_is_load, id_reg_write;
  logic            flush, ex_hold, fwd_rs1, fwd_rs2;
  logic [XLEN-1:0] alu_result, wb_data;
  logic            ex_valid;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_op_a, ex_op_b;
  logic [3:0]      ex_alu_op;
  logic            ex_is_load, ex_reg_write, stall_id;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_is_load(id_is_load),
    .id_reg_write(id_reg_write), .flush(flush), .ex_hold(ex_hold),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .alu_result(alu_result), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_alu_op(ex_alu_op),
    .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .stall_id(stall_id)
  );

  typedef struct {
    logic            valid;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      alu_op;
    logic            is_load, reg_write, stall;
    logic [XLEN-1:0] op_a, op_b;
  } snap_t;

  snap_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  // Reference model: the instruction held in EX, last ALU result, and how
  // many edges ago a load-use hazard was detected (0 = none pending).
  logic            m_valid, m_use_imm, m_is_load, m_rw;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [XLEN-1:0] m_v1, m_v2, m_imm, m_last;
  logic [3:0]      m_op;
  int              lu_age;
  bit              lu_a, lu_b;

  task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_use_imm = 0; m_is_load = 0; m_rw = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_v1 = 0; m_v2 = 0; m_imm = 0; m_last = 0; m_op = 0;
    lu_age = 0; lu_a = 0; lu_b = 0;
  endtask

  function automatic logic [XLEN-1:0] pick(logic [4:0] idx, logic f, logic lf,
                                           logic [XLEN-1:0] last, logic [XLEN-1:0] wb,
                                           logic [XLEN-1:0] rf);
    if (idx == 0) return '0;
    if (f)        return last;
    if (lf)       return wb;
    return rf;
  endfunction

  // Called once per cycle after inputs settle: push expected outputs, then
  // advance the model across the coming rising edge.
  task automatic model_step();
    snap_t s;
    bit hazard;
    if (!reset) model_reset();
    hazard = LU && reset && (lu_age == 0) && id_valid && m_valid && m_is_load &&
             (m_rd != 0) && (id_rs1 == m_rd || id_rs2 == m_rd) && !flush && !ex_hold;
    s.valid = m_valid; s.rs1 = m_rs1; s.rs2 = m_rs2; s.rd = m_rd;
    s.alu_op = m_op; s.is_load = m_is_load; s.reg_write = m_rw;
    s.stall = reset && (ex_hold || hazard);
    s.op_a = pick(m_rs1, fwd_rs1, (lu_age == 2) && lu_a, m_last, wb_data, m_v1);
    s.op_b = m_use_imm ? m_imm : pick(m_rs2, fwd_rs2, (lu_age == 2) && lu_b, m_last, wb_data, m_v2);
    sb_q.push_back(s);
    if (!reset) return;
    if (!ex_hold && m_valid) m_last = alu_result;
    if (flush) lu_age = 0;
    else if (!ex_hold) begin
      if (hazard) begin
        lu_age = 1; lu_a = (id_rs1 == m_rd); lu_b = (id_rs2 == m_rd);
      end else if (lu_age == 1) lu_age = 2;
      else lu_age = 0;
    end
    if (flush) m_valid = 0;
    else if (!ex_hold) begin
      if (hazard) begin
        m_valid = 0; m_rd = 0; m_rw = 0;
      end else begin
        m_valid = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
        m_v1 = id_rs1_val; m_v2 = id_rs2_val; m_imm = id_imm; m_use_imm = id_use_imm;
        m_op = id_alu_op; m_is_load = id_is_load; m_rw = id_reg_write;
      end
    end
  endtask

  task automatic begin_cycle();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    #1 model_step();
    #2;
  endtask

  task automatic quiet();
    reset = 1; flush = 0; ex_hold = 0; fwd_rs1 = 0; fwd_rs2 = 0;
  endtask

  task automatic set_id(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                        logic [XLEN-1:0] v1, logic [XLEN-1:0] v2, logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_val = v1; id_rs2_val = v2; id_imm = 32'h0; id_use_imm = 0;
    id_alu_op = 4'h1; id_is_load = ld; id_reg_write = 1;
  endtask

  task automatic rand_inputs();
    int r;
    reset = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
    id_valid = ($urandom_range(3) != 0);
    id_rs1 = 5'($urandom_range(3));
    id_rs2 = 5'($urandom_range(3));
    id_rd = 5'($urandom_range(3));
    id_rs1_val = $urandom(); id_rs2_val = $urandom(); id_imm = $urandom();
    id_use_imm = ($urandom_range(3) == 0);
    id_alu_op = 4'($urandom_range(15));
    id_is_load = 1'($urandom_range(1));
    id_reg_write = 1'($urandom_range(1));
    r = $urandom_range(99);
    flush = (r < 8);
    ex_hold = (r >= 8 && r < 18);
    fwd_rs1 = ($urandom_range(3) == 0);
    fwd_rs2 = ($urandom_range(3) == 0);
    alu_result = $urandom(); wb_data = $urandom();
  endtask

  // Monitor: compare DUT outputs against the oldest expected snapshot.
  initial begin
    snap_t e;
    while (!done) begin
      @(negedge clk); #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_ex_valid", ex_valid, e.valid);
        chk("sb_ex_rs1", ex_rs1, e.rs1);
        chk("sb_ex_rs2", ex_rs2, e.rs2);
        chk("sb_ex_rd", ex_rd, e.rd);
        chk("sb_ex_alu_op", ex_alu_op, e.alu_op);
        chk("sb_ex_is_load", ex_is_load, e.is_load);
        chk("sb_ex_reg_write", ex_reg_write, e.reg_write);
        chk("sb_stall_id", stall_id, e.stall);
        chk("sb_ex_op_a", ex_op_a, e.op_a);
        chk("sb_ex_op_b", ex_op_b, e.op_b);
      end
    end
  end

  initial begin
    reset = 0; quiet(); reset = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    alu_result = 0; wb_data = 0;
    model_reset();

    // Reset with random inputs and hold asserted.
    begin_cycle(); rand_inputs(); reset = 0; ex_hold = 1; end_cycle();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_ex_alu_op", ex_alu_op, 0);
    chk("rst_ex_op_a", ex_op_a, 0);
    chk("rst_ex_op_b", ex_op_b, 0);
    chk("rst_stall_id", stall_id, 0);

    // Release: rd=5 shows up one cycle later.
    begin_cycle(); quiet(); set_id(1, 1, 2, 5, 1, 2, 0); end_cycle();
    begin_cycle(); quiet(); id_valid = 0; end_cycle();
    chk("rel_ex_valid", ex_valid, 1);
    chk("rel_ex_rd", ex_rd, 5);

    // ALU forward followed by x0 guard.
    begin_cycle(); quiet(); set_id(1, 1, 2, 3, 1, 2, 0); end_cycle();
    begin_cycle(); quiet(); set_id(1, 3, 2, 4, 32'hDEAD, 2, 0); alu_result = 32'h10; end_cycle();
    begin_cycle(); quiet(); set_id(1, 0, 2, 6, 32'h1234, 2, 0); alu_result = 32'h99; fwd_rs1 = 1; end_cycle();
    chk("fwd_ex_op_a", ex_op_a, 32'h10);
    begin_cycle(); quiet(); id_valid = 0; fwd_rs1 = 1; end_cycle();
    chk("x0_ex_op_a", ex_op_a, 32'h0);

    // Load to x7 followed by a consumer reading rs2=7.
    begin_cycle(); quiet(); set_id(1, 1, 2, 7, 1, 2, 1); wb_data = 0; end_cycle();
    begin_cycle(); quiet(); set_id(1, 1, 7, 8, 32'h1, 32'hBAD, 0); end_cycle();
`ifdef IDEX_LOAD_USE_EN
    chk("lu_stall_on", stall_id, 1);
    begin_cycle(); quiet(); end_cycle();
    chk("lu_stall_off", stall_id, 0);
    chk("lu_bubble_valid", ex_valid, 0);
    begin_cycle(); quiet(); id_valid = 0; wb_data = 32'h55; end_cycle();
    chk("lu_cons_valid", ex_valid, 1);
    chk("lu_ex_op_b", ex_op_b, 32'h55);
    chk("lu_ex_op_a", ex_op_a, 32'h1);
`else
    chk("nolu_stall", stall_id, 0);
    begin_cycle(); quiet(); id_valid = 0; wb_data = 32'h55; end_cycle();
    chk("nolu_cons_valid", ex_valid, 1);
    chk("nolu_ex_op_b", ex_op_b, 32'hBAD);
`endif

    // Flush on the hazard edge: no bubble state, no wb_data forwarding.
    begin_cycle(); quiet(); set_id(1, 1, 2, 7, 1, 2, 1); wb_data = 0; end_cycle();
    begin_cycle(); quiet(); set_id(1, 1, 7, 8, 32'h1, 32'hBAD, 0); flush = 1; end_cycle();
    chk("fl_stall", stall_id, 0);
    begin_cycle(); quiet(); end_cycle();
    chk("fl_ex_valid", ex_valid, 0);
    begin_cycle(); quiet(); id_valid = 0; wb_data = 32'h55; end_cycle();
    chk("fl_cons_valid", ex_valid, 1);
    chk("fl_ex_op_b", ex_op_b, 32'hBAD);

    // Randomized traffic with dense register reuse.
    for (int i = 0; i < 3000; i++) begin
      begin_cycle(); rand_inputs(); end_cycle();
    end

    repeat (2) @(negedge clk);
    #3;
    chk("sb_drain", sb_q.size(), 0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID→EX pipeline register and EX-side operand selector. Latches decoded instructions from Decode and builds the two ALU operands. Operand sources are the register-file values, the forwarded previous ALU result (selected by the registered forwarding flags from the forwarding control block), or write-back data after a load-use bubble. The block also inserts the one-cycle load-use bubble and exports the current EX-stage `rs1`/`rs2`/`rd` that the forwarding control block consumes.

## Interface

Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; block is in reset while `reset`=0.
- `id_valid`  in  1  Decode presents an instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_rs1_val`, `id_rs2_val`  in  XLEN each  register-file read data.
- `id_imm`  in  XLEN  immediate.
- `id_use_imm`  in  1  operand B = immediate.
- `id_alu_op`  in  4  ALU opcode, passed through.
- `id_is_load`, `id_reg_write`  in  1 each  control bits, passed through.
- `flush`  in  1  branch redirect; kill the instruction entering EX.
- `ex_hold`  in  1  downstream busy; freeze the EX register.
- `fwd_rs1`, `fwd_rs2`  in  1 each  forwarding flags from the forwarding control block.
- `alu_result`  in  XLEN  ALU output of the instruction currently in EX.
- `wb_data`  in  XLEN  write-back data (load return).
- `ex_valid`  out  1  EX holds a live instruction.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  EX-stage indices to the forwarding control block.
- `ex_op_a`, `ex_op_b`  out  XLEN each  ALU operands (combinational).
- `ex_alu_op`  out  4.
- `ex_is_load`, `ex_reg_write`  out  1 each.
- `stall_id`  out  1  Decode/Fetch must hold their current instruction.

## Operation

- EX register update rules, checked in this priority order on each rising edge:
  - `flush`: `ex_valid`←0.
  - else `ex_hold`: all EX fields unchanged.
  - else bubble (see FSM): `ex_valid`←0, `ex_rd`←0, `ex_reg_write`←0.
  - else: load all `id_*` fields; `ex_valid`←`id_valid`.
- `last_result` register: captures `alu_result` on each non-held edge where `ex_valid`=1.
- Operand A: if `ex_rs1`=0, value 0. Else if `fwd_rs1`, `last_result`. Else if `lu_fwd_a`, `wb_data`. Else the latched `rs1_val`.
- Operand B: if `use_imm`, the immediate. Otherwise the same chain as operand A, using `rs2` signals.
- FSM states:
  - RUN → BUBBLE when all hold: `id_valid`, `ex_valid`, `ex_is_load`, `ex_rd`≠0, (`id_rs1`=`ex_rd` or `id_rs2`=`ex_rd`), and no `flush`/`ex_hold`.
  - BUBBLE → LU_FWD unconditionally, unless `flush` (→ RUN).
  - LU_FWD → RUN on the next non-held edge.
- `stall_id`=1 in RUN only while the BUBBLE condition is true (combinational). It is also 1 whenever `ex_hold`=1.
- In LU_FWD, `lu_fwd_a`/`lu_fwd_b` are set for each operand whose index matched the load's `rd`. The match is captured on RUN→BUBBLE.
- In LU_FWD the register forwarding flags still take priority.
- Arithmetic: none. All selects are pure multiplexing at XLEN.

## Timing

- Reset values: `ex_valid`=0, `ex_rs1`=`ex_rs2`=`ex_rd`=0, `ex_alu_op`=0, `ex_is_load`=`ex_reg_write`=0, `last_result`=0, FSM=RUN, `stall_id`=0.
- With reset held, `ex_op_a`=`ex_op_b`=0.
- Latency: an ID instruction appears at EX outputs 1 cycle later. A load-use pair costs exactly 1 bubble cycle.
- `fwd_rs1`/`fwd_rs2` arrive registered mid-cycle (negedge) and are used combinationally. Their only requirement is to settle before the next rising edge.
- Simultaneous events:
  - `flush` with a BUBBLE condition: flush wins and the FSM stays RUN.
  - `ex_hold` in any state freezes the FSM.
  - Reset deasserted mid-BUBBLE: the FSM restarts in RUN.

## Configuration

- `IDEX_LOAD_USE_EN` defined: the FSM, bubble insertion, `lu_fwd_*` and `wb_data` forwarding are present.
- Undefined:
  - FSM is absent; `stall_id`=`ex_hold`; `wb_data` is unused.
  - Load-use hazards are the compiler's responsibility.

## Test plan

- Reset: drive `reset`=0 with random inputs → all outputs at their reset values; after release, `id_valid`=1 with rd=5 → `ex_valid`=1, `ex_rd`=5 one cycle later.
- ALU forward:
  - Instruction A writes x3 with `alu_result`=0x10.
  - Next instruction reads `rs1`=3 with `fwd_rs1`=1 and `id_rs1_val`=0xDEAD.
  - Required: `ex_op_a`=0x10.
- Load-use (macro on):
  - Load to x7 in EX, ID reads `rs2`=7 → `stall_id`=1 for 1 cycle, then `ex_valid`=0 for 1 cycle.
  - Then consumer enters EX with `wb_data`=0x55 → `ex_op_b`=0x55.
- Flush during bubble: set up the load-use case and assert `flush` on the same edge → FSM stays RUN, `ex_valid`=0, no LU_FWD.
- x0 guard: `rs1`=0, `fwd_rs1`=1, `last_result`=0x99 → `ex_op_a`=0.
- Macro off: the load-use case → `stall_id`=0 and no bubble cycle; `ex_op_b`=latched `rs2_val`.
